// File: rtl/eth_sw_rd_arb_if.sv
// Read-scheduler bus for the 2x2 switch core.
// master: the scheduler (samples FIFO status, drives read strobes and statistics).
// slave:  the core / environment side (drives FIFO status, observes read strobes).
interface eth_sw_rd_arb_if #(
    parameter int CNT_W = 16
);
    logic [1:0]       fifo_empty;
    logic [1:0]       port_stall;
    logic             tx_ready;
    logic [1:0]       rd_en;
    logic             grant_port;
    logic             busy;
    logic [CNT_W-1:0] rd_cnt_a;
    logic [CNT_W-1:0] rd_cnt_b;

    modport master (
        input  fifo_empty,
        input  port_stall,
        input  tx_ready,
        output rd_en,
        output grant_port,
        output busy,
        output rd_cnt_a,
        output rd_cnt_b
    );

    modport slave (
        output fifo_empty,
        output port_stall,
        output tx_ready,
        input  rd_en,
        input  grant_port,
        input  busy,
        input  rd_cnt_a,
        input  rd_cnt_b
    );
endinterface

// File: rtl/eth_sw_rd_arb.sv
// Round-robin read scheduler for the two ingress FIFOs of the switch core.
// Each grant is a single-cycle READ followed by a settle gap; a port keeps the
// grant for up to MAX_BURST reads while the other port is eligible.
// rd_en and busy are registered from the next-state decode so they are glitch-free.
module eth_sw_rd_arb #(
    parameter int PORT_COUNT = 2,
    parameter int MAX_BURST  = 4,
    parameter int GAP_CYCLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rstn,
    eth_sw_rd_arb_if.master   bus
);

    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
    localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_SAT   = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [BURST_W-1:0]   burst_cnt, burst_cnt_n;
    logic [GAP_W-1:0]     gap_cnt, gap_cnt_n;
    logic                 grant, grant_n;
    logic                 last_grant, last_grant_n;
    logic [PORT_COUNT-1:0] elig;

    logic [1:0]           rd_en_q;
    logic                 busy_q;
    logic [CNT_W-1:0]     cnt_a, cnt_b;

    assign elig = ~bus.fifo_empty & ~bus.port_stall;

    // State and scheduling registers; reset leaves last_grant on B so A wins the first tie.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            gap_cnt    <= '0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_n;
            burst_cnt  <= burst_cnt_n;
            gap_cnt    <= gap_cnt_n;
            grant      <= grant_n;
            last_grant <= last_grant_n;
        end
    end

    // Next-state logic: eligibility is only consulted in IDLE and on the last gap cycle.
    always_comb begin
        state_n      = state;
        burst_cnt_n  = burst_cnt;
        gap_cnt_n    = gap_cnt;
        grant_n      = grant;
        last_grant_n = last_grant;
        case (state)
            IDLE: begin
                if (bus.tx_ready && (|elig)) begin
                    grant_n     = elig[~last_grant] ? ~last_grant : last_grant;
                    burst_cnt_n = '0;
                    state_n     = READ;
                end
            end
            READ: begin
                burst_cnt_n  = burst_cnt + 1'b1;
                last_grant_n = grant;
                gap_cnt_n    = '0;
                state_n      = GAP;
            end
            GAP: begin
                if (gap_cnt != GAP_LAST) begin
                    gap_cnt_n = gap_cnt + 1'b1;
                end else if (!bus.tx_ready || !(|elig)) begin
                    state_n = IDLE;
                end else if (burst_cnt == BURST_MAX) begin
                    if (elig[~grant]) begin
                        grant_n = ~grant;
                    end
                    burst_cnt_n = '0;
                    state_n     = READ;
                end else if (elig[grant]) begin
                    state_n = READ;
                end else begin
                    grant_n     = ~grant;
                    burst_cnt_n = '0;
                    state_n     = READ;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Registered strobes: rd_en is high exactly while the state register holds READ.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_en_q <= 2'b00;
            busy_q  <= 1'b0;
        end else begin
            rd_en_q <= (state_n == READ) ? (grant_n ? 2'b10 : 2'b01) : 2'b00;
            busy_q  <= (state_n != IDLE);
        end
    end

    // Per-port read statistics, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else if (state == READ) begin
            if (!grant) begin
                if (cnt_a != CNT_SAT) begin
                    cnt_a <= cnt_a + 1'b1;
                end
            end else begin
                if (cnt_b != CNT_SAT) begin
                    cnt_b <= cnt_b + 1'b1;
                end
            end
        end
    end

    assign bus.rd_en      = rd_en_q;
    assign bus.grant_port = grant;
    assign bus.busy       = busy_q;
    assign bus.rd_cnt_a   = cnt_a;
    assign bus.rd_cnt_b   = cnt_b;

endmodule

// File: tb/tb_eth_sw_rd_arb.sv
// Directed testbench for eth_sw_rd_arb: round-robin, burst limit, tx_ready gating,
// stall handling, mid-gap reset and counter saturation (on a narrow-counter instance).
module tb_eth_sw_rd_arb;

    logic clk;
    logic rstn;
    int   total;
    int   bad;

    eth_sw_rd_arb_if #(.CNT_W(16)) bus ();
    eth_sw_rd_arb_if #(.CNT_W(2))  sat_bus ();

    eth_sw_rd_arb #(
        .PORT_COUNT(2), .MAX_BURST(4), .GAP_CYCLES(1), .CNT_W(16)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus.master)
    );

    eth_sw_rd_arb #(
        .PORT_COUNT(2), .MAX_BURST(4), .GAP_CYCLES(1), .CNT_W(2)
    ) dut_sat (
        .clk (clk),
        .rstn(rstn),
        .bus (sat_bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hold reset for two edges with the current inputs, release on a falling edge.
    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        bus.fifo_empty = 2'b00;
        bus.port_stall = 2'b00;
        bus.tx_ready   = 1'b1;
        sat_bus.fifo_empty = 2'b00;
        sat_bus.port_stall = 2'b00;
        sat_bus.tx_ready   = 1'b1;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.rd_en !== 2'b00) begin
            bad++; $display("[TB] FAIL reset_rd_en got=%b exp=00", bus.rd_en);
        end
        total++;
        if (bus.grant_port !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_grant_busy got=%b%b exp=00", bus.grant_port, bus.busy);
        end
        total++;
        if (bus.rd_cnt_a !== 16'h0 || bus.rd_cnt_b !== 16'h0) begin
            bad++; $display("[TB] FAIL reset_cnt got=%h/%h exp=0000/0000", bus.rd_cnt_a, bus.rd_cnt_b);
        end
        total++;
        if (sat_bus.rd_en !== 2'b00 || sat_bus.rd_cnt_a !== 2'd0) begin
            bad++; $display("[TB] FAIL reset_sat got=%b/%0d exp=00/0", sat_bus.rd_en, sat_bus.rd_cnt_a);
        end
        sat_bus.tx_ready = 1'b0;
    endtask

    // A only: pulse every second cycle, B never strobed.
    task automatic test_single_port();
        logic [1:0] exp;
        bus.fifo_empty = 2'b10;
        bus.port_stall = 2'b00;
        bus.tx_ready   = 1'b1;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp = (k % 2 == 1) ? 2'b01 : 2'b00;
            total++;
            if (bus.rd_en !== exp || bus.busy !== 1'b1) begin
                bad++; $display("[TB] FAIL t1_rd_en k=%0d got=%b busy=%b exp=%b busy=1", k, bus.rd_en, bus.busy, exp);
            end
        end
        total++;
        if (bus.rd_cnt_a !== 16'd4 || bus.rd_cnt_b !== 16'd0) begin
            bad++; $display("[TB] FAIL t1_cnt got=%0d/%0d exp=4/0", bus.rd_cnt_a, bus.rd_cnt_b);
        end
    endtask

    // Both ports busy: bursts of four alternate A, B, A...
    task automatic test_round_robin();
        logic [1:0] exp;
        int         j;
        logic       port;
        bus.fifo_empty = 2'b00;
        bus.port_stall = 2'b00;
        bus.tx_ready   = 1'b1;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            j    = (k - 1) / 2;
            port = ((j / 4) % 2) == 1;
            exp  = (k % 2 == 1) ? (port ? 2'b10 : 2'b01) : 2'b00;
            total++;
            if (bus.rd_en !== exp) begin
                bad++; $display("[TB] FAIL t2_rd_en k=%0d got=%b exp=%b", k, bus.rd_en, exp);
            end
            if (k % 2 == 1) begin
                total++;
                if (bus.grant_port !== port) begin
                    bad++; $display("[TB] FAIL t2_grant k=%0d got=%b exp=%b", k, bus.grant_port, port);
                end
            end
        end
        total++;
        if (bus.rd_cnt_a !== 16'd6 || bus.rd_cnt_b !== 16'd4) begin
            bad++; $display("[TB] FAIL t2_cnt got=%0d/%0d exp=6/4", bus.rd_cnt_a, bus.rd_cnt_b);
        end
    endtask

    // No reads while tx_ready is low; first read one cycle after it rises.
    task automatic test_tx_ready();
        bus.fifo_empty = 2'b00;
        bus.port_stall = 2'b00;
        bus.tx_ready   = 1'b0;
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            total++;
            if (bus.rd_en !== 2'b00 || bus.busy !== 1'b0) begin
                bad++; $display("[TB] FAIL t3_idle k=%0d got=%b busy=%b exp=00 busy=0", k, bus.rd_en, bus.busy);
            end
        end
        bus.tx_ready = 1'b1;
        @(negedge clk);
        total++;
        if (bus.rd_en !== 2'b01 || bus.busy !== 1'b1) begin
            bad++; $display("[TB] FAIL t3_start got=%b busy=%b exp=01 busy=1", bus.rd_en, bus.busy);
        end
    endtask

    // B stalled: only A is read; releasing the stall at the burst end hands over to B.
    task automatic test_stall();
        logic [1:0] exp;
        bus.fifo_empty = 2'b00;
        bus.port_stall = 2'b10;
        bus.tx_ready   = 1'b1;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp = (k % 2 == 1) ? 2'b01 : 2'b00;
            total++;
            if (bus.rd_en !== exp) begin
                bad++; $display("[TB] FAIL t4_stall k=%0d got=%b exp=%b", k, bus.rd_en, exp);
            end
        end
        bus.port_stall = 2'b00;
        @(negedge clk);
        total++;
        if (bus.rd_en !== 2'b10 || bus.grant_port !== 1'b1) begin
            bad++; $display("[TB] FAIL t4_switch got=%b grant=%b exp=10 grant=1", bus.rd_en, bus.grant_port);
        end
    endtask

    // Reset in the gap after the third A read, then a fresh four-read A burst.
    task automatic test_mid_reset();
        logic [1:0] exp;
        int         j;
        bus.fifo_empty = 2'b00;
        bus.port_stall = 2'b00;
        bus.tx_ready   = 1'b1;
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            exp = (k % 2 == 1) ? 2'b01 : 2'b00;
            total++;
            if (bus.rd_en !== exp) begin
                bad++; $display("[TB] FAIL t5_pre k=%0d got=%b exp=%b", k, bus.rd_en, exp);
            end
        end
        rstn = 1'b0;
        @(negedge clk);
        total++;
        if (bus.rd_en !== 2'b00 || bus.busy !== 1'b0 || bus.grant_port !== 1'b0 ||
            bus.rd_cnt_a !== 16'd0 || bus.rd_cnt_b !== 16'd0) begin
            bad++; $display("[TB] FAIL t5_reset got=%b busy=%b grant=%b cnt=%0d/%0d exp=00 0 0 0/0",
                            bus.rd_en, bus.busy, bus.grant_port, bus.rd_cnt_a, bus.rd_cnt_b);
        end
        rstn = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            j   = (k - 1) / 2;
            exp = (k % 2 == 1) ? ((j < 4) ? 2'b01 : 2'b10) : 2'b00;
            total++;
            if (bus.rd_en !== exp) begin
                bad++; $display("[TB] FAIL t5_post k=%0d got=%b exp=%b", k, bus.rd_en, exp);
            end
        end
    endtask

    // Narrow 2-bit counter: climbs 0..3 then holds at all-ones.
    task automatic test_saturation();
        int exp;
        bus.tx_ready       = 1'b0;
        sat_bus.fifo_empty = 2'b10;
        sat_bus.port_stall = 2'b00;
        sat_bus.tx_ready   = 1'b1;
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp = (k / 2 > 3) ? 3 : k / 2;
            total++;
            if (sat_bus.rd_cnt_a !== 2'(exp) || sat_bus.rd_cnt_b !== 2'd0) begin
                bad++; $display("[TB] FAIL t6_sat k=%0d got=%0d/%0d exp=%0d/0", k, sat_bus.rd_cnt_a, sat_bus.rd_cnt_b, exp);
            end
        end
        sat_bus.tx_ready = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        test_reset();
        test_single_port();
        test_round_robin();
        test_tx_ready();
        test_stall();
        test_mid_reset();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
